// File: rtl/shared_mem_arb.sv
// Single-array RAM shared by the instruction fetch (IF) and data (DM) ports.
// A two-state FSM grants one port per access and performs the access on the
// grant edge. Responses are registered and appear one cycle later as a
// one-cycle ack, so the array serves at most one access every two cycles.
// Word-aligned, range-checked addressing: an out-of-range access is acked
// with err = 1 and rdata = 0, and the array is not touched.
module shared_mem_arb #(
  parameter int    DATA_W   = 32,
  parameter int    DEPTH    = 4096,
  parameter int    ADDR_W   = 32,
  parameter int    ARB_MODE = 0,
  parameter string MEM_INIT = "imem.txt"
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_err_o,
  input  logic                dm_req_i,
  input  logic                dm_sel_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic                dm_wen_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_ack_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_err_o
);

  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable in the range compare.
  localparam logic [IDX_W:0] DEPTH_X = (IDX_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t            state;
  logic              rr_last_dm;   // 1 = DM won the most recent tie, 0 = IF
  logic [DATA_W-1:0] mem [DEPTH];

  logic              if_v;
  logic              dm_v;
  logic              tie;
  logic              grant_dm;
  logic              oor;
  logic              do_wr;
  logic [ADDR_W-1:0] addr_sel;
  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] widx;
  logic              unused_addr;

  // Byte-offset bits never select anything; accesses are word-aligned.
  assign unused_addr = ^{if_addr_i[OFF_W-1:0], dm_addr_i[OFF_W-1:0]};

  // Arbitration and address decode for the port that would be granted now.
  always_comb begin
    if_v     = if_req_i;
    dm_v     = dm_req_i && dm_sel_i;
    tie      = if_v && dm_v;
    // Mode 0: DM wins every tie. Mode 1: the loser of the last tie wins.
    grant_dm = dm_v && (!if_v || (ARB_MODE == 0) || !rr_last_dm);
    addr_sel = grant_dm ? dm_addr_i : if_addr_i;
    idx      = addr_sel[ADDR_W-1:OFF_W];
    oor      = ({1'b0, idx} >= DEPTH_X);
    widx     = idx[MEM_AW-1:0];
    do_wr    = (state == IDLE) && grant_dm && dm_wen_i && !oor;
  end

  // Byte-enabled array write, committed on the grant edge; held off in reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (dm_be_i[b]) mem[widx][b*8 +: 8] <= dm_wdata_i[b*8 +: 8];
      end
    end
  end

  // Grant FSM with registered ack/err/rdata per port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_last_dm <= 1'b0;
      if_ack_o   <= 1'b0;
      if_err_o   <= 1'b0;
      if_rdata_o <= '0;
      dm_ack_o   <= 1'b0;
      dm_err_o   <= 1'b0;
      dm_rdata_o <= '0;
    end else begin
      if_ack_o <= 1'b0;
      if_err_o <= 1'b0;
      dm_ack_o <= 1'b0;
      dm_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (if_v || dm_v) begin
            state <= RESP;
            if (tie && (ARB_MODE != 0)) rr_last_dm <= grant_dm;
            if (grant_dm) begin
              dm_ack_o <= 1'b1;
              dm_err_o <= oor;
              // A write leaves dm_rdata_o alone unless it is out of range.
              if (oor) dm_rdata_o <= '0;
              else if (!dm_wen_i) dm_rdata_o <= mem[widx];
            end else begin
              if_ack_o   <= 1'b1;
              if_err_o   <= oor;
              if_rdata_o <= oor ? '0 : mem[widx];
            end
          end
        end
        RESP: begin
          // Requests are not sampled here; every access costs two cycles.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
